// File: rtl/syst_x_feeder.sv
// syst_x_feeder
//   Drive side of the systolic-array x path. Whole input vectors arrive over a
//   valid/ready handshake and are buffered in a small FIFO. Each popped vector
//   is presented to the array rows with diagonal skew, so lane k lags lane 0
//   by k cycles. After the last vector of a burst, zero flush cycles drain the
//   array and done_o pulses for one cycle.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-low
//   vec_valid_i  input vector valid
//   vec_ready_o  FIFO can accept a vector (registered)
//   vec_data_i   input vector, lane k in [k*X_WIDTH +: X_WIDTH]
//   vec_last_i   vector is last of its burst
//   x_o          skewed lane outputs, same packing as vec_data_i
//   x_valid_o    per-lane element valid
//   busy_o       FSM not IDLE
//   done_o       one-cycle pulse once a burst has fully drained
//
// FSM states
//   state    | meaning
//   S_IDLE   | no burst in progress; pops a waiting vector to start one
//   S_STREAM | burst in progress; one pop per cycle while FIFO non-empty
//   S_FLUSH  | last vector popped; zeros drain the array, done on final cycle
module syst_x_feeder #(
    parameter int N       = 4,
    parameter int X_WIDTH = 8,
    parameter int DEPTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   vec_valid_i,
    output logic                   vec_ready_o,
    input  logic [N*X_WIDTH-1:0]   vec_data_i,
    input  logic                   vec_last_i,
    output logic [N*X_WIDTH-1:0]   x_o,
    output logic [N-1:0]           x_valid_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [FW-1:0]          r_flush_cnt;

    logic [N*X_WIDTH-1:0]   r_mem_data [0:DEPTH-1];
    logic                   r_mem_last [0:DEPTH-1];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_next;
    logic                   r_ready;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_empty;
    logic [N*X_WIDTH-1:0]   w_head_data;
    logic                   w_head_last;

    // ------------------------------------------------------------------ FIFO
    assign w_push       = vec_valid_i && r_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_head_data  = r_mem_data[r_rd_ptr];
    assign w_head_last  = r_mem_last[r_rd_ptr];
    assign vec_ready_o  = r_ready;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= vec_data_i;
            r_mem_last[r_wr_ptr] <= vec_last_i;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            // Registered from the next count so ready already reflects
            // this cycle's push/pop.
            r_ready <= (w_count_next < CW'(DEPTH));
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            // Starts at 0 on the first FLUSH cycle; the done cycle is count N.
            if (r_state != S_FLUSH) r_flush_cnt <= '0;
            else                    r_flush_cnt <= r_flush_cnt + FW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_STREAM: begin
                if (!w_fifo_empty) begin
                    w_state_next = w_head_last ? S_FLUSH : S_STREAM;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == FW'(N)) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop  = (r_state != S_FLUSH) && !w_fifo_empty;
        busy_o = (r_state != S_IDLE);
        done_o = (r_state == S_FLUSH) && (r_flush_cnt == FW'(N));
    end

    // ------------------------------------------------------------ skew lines
    // Lane k has k+1 register stages; bubbles and flush cycles enter as
    // zero data with valid 0, so invalid lanes never show stale values.
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [X_WIDTH-1:0] r_dly_data [0:k];
        logic               r_dly_vld  [0:k];

        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                for (int i = 0; i <= k; i++) begin
                    r_dly_data[i] <= '0;
                    r_dly_vld[i]  <= 1'b0;
                end
            end else begin
                r_dly_data[0] <= w_pop ? w_head_data[k*X_WIDTH +: X_WIDTH] : '0;
                r_dly_vld[0]  <= w_pop;
                for (int i = 1; i <= k; i++) begin
                    r_dly_data[i] <= r_dly_data[i-1];
                    r_dly_vld[i]  <= r_dly_vld[i-1];
                end
            end
        end

        assign x_o[k*X_WIDTH +: X_WIDTH] = r_dly_data[k];
        assign x_valid_o[k]              = r_dly_vld[k];
    end

endmodule

// File: tb/tb_syst_x_feeder.sv
// Testbench for syst_x_feeder. The reference model tracks the FIFO as a
// queue, records what lane 0 emits each cycle, and derives lane k at cycle t
// from the lane-0 emission at t-k. Burst timing comes from the rule "last
// popped at c -> done at c+N+1, next pop no earlier than c+N+2".
module tb_syst_x_feeder;

    localparam int N     = 4;
    localparam int XW    = 8;
    localparam int DEPTH = 4;
    localparam int MAXC  = 4000;

    logic              clk_i;
    logic              rst_i;
    logic              vec_valid_i;
    logic              vec_ready_o;
    logic [N*XW-1:0]   vec_data_i;
    logic              vec_last_i;
    logic [N*XW-1:0]   x_o;
    logic [N-1:0]      x_valid_o;
    logic              busy_o;
    logic              done_o;

    syst_x_feeder #(.N(N), .X_WIDTH(XW), .DEPTH(DEPTH)) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .vec_valid_i (vec_valid_i),
        .vec_ready_o (vec_ready_o),
        .vec_data_i  (vec_data_i),
        .vec_last_i  (vec_last_i),
        .x_o         (x_o),
        .x_valid_o   (x_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [N*XW-1:0] q_d [$];
    bit              q_l [$];
    logic [N*XW-1:0] em_d [0:MAXC];
    bit              em_v [0:MAXC];
    int  cyc           = 0;
    int  last_rst      = 0;
    int  first_pop     = -1;
    int  done_cyc      = -1;
    int  blocked_until = 0;
    bit  rst_low_prev  = 1'b1;
    bit  acc           = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [N*XW-1:0] exp_x;
        logic [N-1:0]    exp_v;
        bit              rdy;
        bit              do_pop;
        logic [N*XW-1:0] hd;
        bit              hl;
        @(negedge clk_i);
        exp_x = '0;
        exp_v = '0;
        for (int k = 0; k < N; k++) begin
            int e;
            e = cyc - k;
            if (e > last_rst && em_v[e]) begin
                exp_x[k*XW +: XW] = em_d[e][k*XW +: XW];
                exp_v[k]          = 1'b1;
            end
        end
        rdy = !rst_low_prev && (q_d.size() < DEPTH);
        chk($sformatf("x_o@%0d", cyc), 64'(x_o), 64'(exp_x));
        chk($sformatf("x_valid_o@%0d", cyc), 64'(x_valid_o), 64'(exp_v));
        chk($sformatf("vec_ready_o@%0d", cyc), 64'(vec_ready_o), 64'(rdy));
        chk($sformatf("done_o@%0d", cyc), 64'(done_o), 64'(cyc == done_cyc));
        chk($sformatf("busy_o@%0d", cyc), 64'(busy_o),
            64'((first_pop >= 0) && (cyc > first_pop) && (done_cyc < 0 || cyc <= done_cyc)));
        acc    = rst_i && vec_valid_i && rdy;
        do_pop = rst_i && (q_d.size() > 0) && (cyc >= blocked_until);
        @(posedge clk_i);
        if (!rst_i) begin
            q_d.delete();
            q_l.delete();
            first_pop     = -1;
            done_cyc      = -1;
            blocked_until = 0;
            last_rst      = cyc;
        end else begin
            if (do_pop) begin
                hd = q_d.pop_front();
                hl = q_l.pop_front();
                em_v[cyc+1] = 1'b1;
                em_d[cyc+1] = hd;
                if (first_pop < 0) first_pop = cyc;
                if (hl) begin
                    done_cyc      = cyc + N + 1;
                    blocked_until = cyc + N + 2;
                end
            end
            if (cyc == done_cyc) begin
                first_pop = -1;
                done_cyc  = -1;
            end
            if (acc) begin
                q_d.push_back(vec_data_i);
                q_l.push_back(vec_last_i);
            end
        end
        rst_low_prev = !rst_i;
        cyc++;
        #1;
    endtask

    task automatic push_vec(input logic [N*XW-1:0] d, input bit l);
        int n;
        n = 0;
        vec_valid_i = 1'b1;
        vec_data_i  = d;
        vec_last_i  = l;
        acc = 1'b0;
        while (!acc && n < 50) begin
            tick();
            n++;
        end
        chk("push_accept", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        vec_valid_i = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [N*XW-1:0] mkvec(input int base);
        logic [N*XW-1:0] v;
        for (int k = 0; k < N; k++) v[k*XW +: XW] = 8'(base + 32*k);
        return v;
    endfunction

    initial begin
        rst_i       = 1'b0;
        vec_valid_i = 1'b0;
        vec_data_i  = '0;
        vec_last_i  = 1'b0;
        @(posedge clk_i);
        #1;
        cyc = 1;

        // 1: reset held with valid asserted, then released
        vec_valid_i = 1'b1;
        vec_data_i  = 32'hDEADBEEF;
        vec_last_i  = 1'b1;
        repeat (3) tick();
        rst_i = 1'b1;
        idle(3);

        // 2: single vector
        push_vec(32'h04030201, 1'b1);
        idle(10);

        // 3: back-to-back burst of 6
        for (int i = 0; i < 6; i++) push_vec(mkvec(8'h10 + i), i == 5);
        idle(15);

        // 4: starvation bubble
        push_vec(mkvec(8'h40), 1'b0);
        idle(2);
        push_vec(mkvec(8'h41), 1'b1);
        idle(12);

        // 5: second burst pushed during flush of the first
        push_vec(mkvec(8'h50), 1'b0);
        push_vec(mkvec(8'h51), 1'b1);
        idle(2);
        push_vec(mkvec(8'h60), 1'b0);
        push_vec(mkvec(8'h61), 1'b1);
        idle(20);

        // 6: reset in the middle of a stream, then a fresh single vector
        for (int i = 0; i < 5; i++) push_vec(mkvec(8'h70 + i), 1'b0);
        vec_valid_i = 1'b0;
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        idle(3);
        push_vec(32'h04030201, 1'b1);
        idle(10);

        // random traffic; data and valid held while not accepted
        acc = 1'b0;
        vec_valid_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!vec_valid_i || acc) begin
                vec_valid_i = ($urandom_range(0, 3) != 0);
                vec_data_i  = $urandom;
                vec_last_i  = ($urandom_range(0, 5) == 0);
            end
            tick();
        end
        push_vec($urandom, 1'b1);
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
